// File: rtl/ntt_pkg.sv
// Shared definitions for the NTT output path: modulus constants, lane count,
// collector FSM states and the canonicalization / bit-reversal helpers.
package ntt_pkg;

  localparam int WIDTH = 18;
  localparam int LANES = 8;

  localparam logic [WIDTH-1:0] PRIME = 18'd65537;
  localparam logic [WIDTH-1:0] N_INV = 18'd57345;  // 8^-1 mod 65537

  // 20-bit signed copies so canonicalization never overflows.
  localparam logic signed [WIDTH+1:0] PRIME_S  = 20'sd65537;
  localparam logic signed [WIDTH+1:0] PRIME2_S = 20'sd131074;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SCALE = 2'd1,
    SEND  = 2'd2
  } state_t;

  // Map a signed 18-bit value into [0, PRIME) by adding k*PRIME, k in {-1,0,1,2}.
  function automatic logic [WIDTH-1:0] canon(input logic [WIDTH-1:0] v);
    logic signed [WIDTH+1:0] s;
    logic signed [WIDTH+1:0] r;
    s = signed'({{2{v[WIDTH-1]}}, v});
    if (s < 0) begin
      if (s + PRIME_S < 0) r = s + PRIME2_S;
      else                 r = s + PRIME_S;
    end else begin
      if (s >= PRIME_S) r = s - PRIME_S;
      else              r = s;
    end
    return r[WIDTH-1:0];
  endfunction

  function automatic logic [2:0] bitrev3(input logic [2:0] i);
    return {i[0], i[1], i[2]};
  endfunction

endpackage

// File: rtl/mod_mul.sv
// Combinational a*b mod 65537 for operands in [0, 65537).
// Uses 2^16 == -1 (mod 65537): p = hi*2^32 + mid*2^16 + lo  ==>  lo - mid + hi.
module mod_mul (
  input  logic [16:0] i_a,
  input  logic [16:0] i_b,
  output logic [16:0] o_p
);

  logic [33:0]        w_prod;
  logic signed [19:0] w_fold;
  logic signed [19:0] w_fix;

  assign w_prod = i_a * i_b;

  // Fold the product using the Fermat-prime identity, then correct into range.
  always_comb begin
    w_fold = signed'({4'b0, w_prod[15:0]})
           - signed'({4'b0, w_prod[31:16]})
           + signed'({18'b0, w_prod[33:32]});
    w_fix = w_fold;
    if (w_fold < 0)              w_fix = w_fold + 20'sd65537;
    else if (w_fold >= 20'sd65537) w_fix = w_fold - 20'sd65537;
    o_p = w_fix[16:0];
  end

endmodule

// File: rtl/ntt_output_collector.sv
// Collects one 8-lane butterfly frame, canonicalizes it, scales INTT frames
// by N^-1, and streams the coefficients out one per valid/ready beat.
// Optional macro OUT_BITREV_EN: emit coefficients in bit-reversed index order.
//
// Handshakes: a transfer happens on a rising edge where valid & ready are both
// high; valid never depends on ready, and while valid is high with ready low
// the payload (out_data/out_index/out_last) holds stable.
module ntt_output_collector
  import ntt_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  input  logic [WIDTH-1:0] in_3,
  input  logic [WIDTH-1:0] in_4,
  input  logic [WIDTH-1:0] in_5,
  input  logic [WIDTH-1:0] in_6,
  input  logic [WIDTH-1:0] in_7,
  input  logic [WIDTH-1:0] in_8,
  input  logic             NTT_INTT_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [2:0]       out_index,
  output logic             out_last,
  output logic             busy,
  output state_t           dbg_state
);

  state_t           r_state;
  state_t           w_next;
  logic [2:0]       r_idx;
  logic [2:0]       r_sidx;
  logic [WIDTH-1:0] r_buf [LANES];
  logic [WIDTH-1:0] w_lanes [LANES];
  logic             w_accept;
  logic [2:0]       w_ord;
  logic [16:0]      w_scaled;

  assign w_lanes[0] = in_1;
  assign w_lanes[1] = in_2;
  assign w_lanes[2] = in_3;
  assign w_lanes[3] = in_4;
  assign w_lanes[4] = in_5;
  assign w_lanes[5] = in_6;
  assign w_lanes[6] = in_7;
  assign w_lanes[7] = in_8;

  assign in_ready  = (r_state == IDLE) & ~rst;
  assign w_accept  = in_valid & in_ready;
  assign busy      = (r_state != IDLE);
  assign dbg_state = r_state;

`ifdef OUT_BITREV_EN
  assign w_ord = bitrev3(r_idx);
`else
  assign w_ord = r_idx;
`endif

  // Buffered values are canonical (< 2^17), so the top bit is always zero.
  mod_mul u_mod_mul (
    .i_a (r_buf[r_sidx][16:0]),
    .i_b (N_INV[16:0]),
    .o_p (w_scaled)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state and output decode. The frame's mode is remembered by which
  // state follows IDLE, so no separate mode register is needed.
  always_comb begin
    w_next    = r_state;
    out_valid = 1'b0;
    out_data  = '0;
    out_index = 3'd0;
    out_last  = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) w_next = NTT_INTT_mode ? SCALE : SEND;
      end
      SCALE: begin
        if (r_sidx == 3'd7) w_next = SEND;
      end
      SEND: begin
        out_valid = 1'b1;
        out_data  = r_buf[w_ord];
        out_index = w_ord;
        out_last  = (r_idx == 3'd7);
        if (out_ready && r_idx == 3'd7) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Beat and scale counters; both wrap to 0 after 7, which clears them at frame end.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_idx  <= 3'd0;
      r_sidx <= 3'd0;
    end else begin
      if (r_state == SCALE)             r_sidx <= r_sidx + 3'd1;
      if (r_state == SEND && out_ready) r_idx  <= r_idx + 3'd1;
    end
  end

  // Frame buffer: whole-frame load on accept, one element rescaled per SCALE cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LANES; i++) r_buf[i] <= '0;
    end else if (w_accept) begin
      for (int i = 0; i < LANES; i++) r_buf[i] <= canon(w_lanes[i]);
    end else if (r_state == SCALE) begin
      r_buf[r_sidx] <= {1'b0, w_scaled};
    end
  end

endmodule

// File: tb/tb_ntt_output_collector.sv
// Directed bench for ntt_output_collector: reset values, NTT/INTT frames,
// canonicalization corners, backpressure, mid-frame reset, reset vs in_valid.
module tb_ntt_output_collector;
  import ntt_pkg::*;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [17:0] in_1, in_2, in_3, in_4, in_5, in_6, in_7, in_8;
  logic        NTT_INTT_mode;
  logic        out_valid;
  logic        out_ready;
  logic [17:0] out_data;
  logic [2:0]  out_index;
  logic        out_last;
  logic        busy;
  state_t      dbg_state;

  always #5 clk = ~clk;

  ntt_output_collector dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_1          (in_1),
    .in_2          (in_2),
    .in_3          (in_3),
    .in_4          (in_4),
    .in_5          (in_5),
    .in_6          (in_6),
    .in_7          (in_7),
    .in_8          (in_8),
    .NTT_INTT_mode (NTT_INTT_mode),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_index     (out_index),
    .out_last      (out_last),
    .busy          (busy),
    .dbg_state     (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int          n_tests = 0;
  int          n_fail  = 0;
  logic [31:0] exp_q[$];
  logic [17:0] lane_v[8];
  logic [31:0] exp_v[8];
  int          ord_tab[8];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic apply_lanes();
    in_1 = lane_v[0]; in_2 = lane_v[1]; in_3 = lane_v[2]; in_4 = lane_v[3];
    in_5 = lane_v[4]; in_6 = lane_v[5]; in_7 = lane_v[6]; in_8 = lane_v[7];
  endtask

  // Offer lane_v for one accept edge; queue exp_v in expected emission order.
  task automatic send_frame(input logic mode);
    int waited;
    waited = 0;
    while (!in_ready && waited < 50) begin
      @(negedge clk);
      waited++;
    end
    check("in_ready_wait", {31'b0, in_ready}, 32'd1);
    apply_lanes();
    NTT_INTT_mode = mode;
    in_valid      = 1'b1;
    for (int b = 0; b < 8; b++) exp_q.push_back(exp_v[ord_tab[b]]);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  // Called at the negedge right after the accept edge.
  task automatic collect_frame(input int exp_lat, input int stall_idx,
                               input int stall_len, input int n_beats);
    int          lat;
    logic [31:0] d;
    lat = 1;
    while (!out_valid && lat < 40) begin
      check("zero_when_invalid", {13'b0, out_data, out_index, out_last}, 32'd0);
      @(negedge clk);
      lat++;
    end
    check("latency", lat, exp_lat);
    for (int b = 0; b < n_beats; b++) begin
      d = (exp_q.size() != 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
      check("valid", {31'b0, out_valid}, 32'd1);
      check("index", {29'b0, out_index}, ord_tab[b]);
      check("data", {14'b0, out_data}, d);
      check("last", {31'b0, out_last}, (b == 7) ? 32'd1 : 32'd0);
      check("in_ready_during_send", {31'b0, in_ready}, 32'd0);
      if (b == stall_idx) begin
        out_ready = 1'b0;
        for (int s = 0; s < stall_len; s++) begin
          @(negedge clk);
          check("hold_valid", {31'b0, out_valid}, 32'd1);
          check("hold_data", {14'b0, out_data}, d);
          check("hold_index", {29'b0, out_index}, ord_tab[b]);
          check("hold_in_ready", {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
      end
      @(negedge clk);
    end
    if (n_beats == 8) begin
      check("post_valid", {31'b0, out_valid}, 32'd0);
      check("post_data", {14'b0, out_data}, 32'd0);
      check("post_in_ready", {31'b0, in_ready}, 32'd1);
      check("post_busy", {31'b0, busy}, 32'd0);
      check("queue_empty", exp_q.size(), 32'd0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
`ifdef OUT_BITREV_EN
    ord_tab = '{0, 4, 2, 6, 1, 5, 3, 7};
`else
    ord_tab = '{0, 1, 2, 3, 4, 5, 6, 7};
`endif
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1; NTT_INTT_mode = 1'b0;
    lane_v = '{18'd0, 18'd0, 18'd0, 18'd0, 18'd0, 18'd0, 18'd0, 18'd0};
    apply_lanes();
    repeat (3) @(negedge clk);

    // Reset values
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_out_data", {14'b0, out_data}, 32'd0);
    check("rst_out_index", {29'b0, out_index}, 32'd0);
    check("rst_out_last", {31'b0, out_last}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd0);
    check("rst_state", {30'b0, dbg_state}, {30'b0, IDLE});
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", {31'b0, in_ready}, 32'd1);

    // NTT pass-through frame
    lane_v = '{18'd0, 18'd4, 18'd2, 18'd6, 18'd1, 18'd5, 18'd3, 18'd7};
    exp_v  = '{32'd0, 32'd4, 32'd2, 32'd6, 32'd1, 32'd5, 32'd3, 32'd7};
    send_frame(1'b0);
    collect_frame(1, -1, 0, 8);

    // Canonicalization corners: -1, PRIME, max positive, min negative
    lane_v = '{18'h3FFFF, 18'h10001, 18'h1FFFF, 18'h20000, 18'd0, 18'd0, 18'd0, 18'd0};
    exp_v  = '{32'd65536, 32'd0, 32'd65534, 32'd2, 32'd0, 32'd0, 32'd0, 32'd0};
    send_frame(1'b0);
    collect_frame(1, -1, 0, 8);

    // INTT scaling: 8*N_INV=1, 1*N_INV, (-1)*N_INV = 8192
    lane_v = '{18'd8, 18'd1, 18'd65536, 18'd0, 18'd0, 18'd0, 18'd0, 18'd0};
    exp_v  = '{32'd1, 32'd57345, 32'd8192, 32'd0, 32'd0, 32'd0, 32'd0, 32'd0};
    send_frame(1'b1);
    collect_frame(9, -1, 0, 8);

    // Backpressure: 3 stalled cycles on the third beat
    lane_v = '{18'd5, 18'd6, 18'd7, 18'd8, 18'd9, 18'd100, 18'd200, 18'd300};
    exp_v  = '{32'd5, 32'd6, 32'd7, 32'd8, 32'd9, 32'd100, 32'd200, 32'd300};
    send_frame(1'b0);
    collect_frame(1, 2, 3, 8);

    // Reset after four completed beats, then a fresh frame from index 0
    lane_v = '{18'd20, 18'd21, 18'd22, 18'd23, 18'd24, 18'd25, 18'd26, 18'd27};
    exp_v  = '{32'd20, 32'd21, 32'd22, 32'd23, 32'd24, 32'd25, 32'd26, 32'd27};
    send_frame(1'b0);
    collect_frame(1, -1, 0, 4);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_out_valid", {31'b0, out_valid}, 32'd0);
    check("midrst_out_data", {14'b0, out_data}, 32'd0);
    check("midrst_busy", {31'b0, busy}, 32'd0);
    check("midrst_in_ready", {31'b0, in_ready}, 32'd0);
    rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check("midrst_release_ready", {31'b0, in_ready}, 32'd1);
    check("midrst_stays_idle", {31'b0, out_valid}, 32'd0);

    lane_v = '{18'd10, 18'd11, 18'd12, 18'd13, 18'd14, 18'd15, 18'd16, 18'd17};
    exp_v  = '{32'd10, 32'd11, 32'd12, 32'd13, 32'd14, 32'd15, 32'd16, 32'd17};
    send_frame(1'b0);
    collect_frame(1, -1, 0, 8);

    // Simultaneous rst and in_valid must not accept
    lane_v = '{18'd1, 18'd2, 18'd3, 18'd4, 18'd5, 18'd6, 18'd7, 18'd8};
    apply_lanes();
    NTT_INTT_mode = 1'b0;
    rst = 1'b1;
    in_valid = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    check("rst_vs_valid_busy", {31'b0, busy}, 32'd0);
    check("rst_vs_valid_out_valid", {31'b0, out_valid}, 32'd0);
    @(negedge clk);
    check("rst_vs_valid_state", {30'b0, dbg_state}, {30'b0, IDLE});
    check("rst_vs_valid_out_valid2", {31'b0, out_valid}, 32'd0);

    // ---------------- final report ----------------
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global time bound
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
